// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//   Two-requester round-robin arbiter in front of a small bitwise logic unit.
//   One operation is in flight at a time. Every result is computed through
//   one shared instance each of the AND / OR / XOR / NOT primitives below.
//   NOR takes two steps: OR into a temp register, then NOT of that temp.
//
// Primitive modules (same file):
//   logic_unit_and / _or / _xor : a_i, b_i -> y_o   (bitwise, WIDTH bits)
//   logic_unit_not              : a_i      -> y_o   (bitwise, WIDTH bits)
//
// Top-level ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid / reqN_ready      request handshake for requester N (0, 1)
//   reqN_op [2:0]                opcode: 000 AND, 001 OR, 010 XOR,
//                                011 NOT(a), 100 NOR, 101-111 illegal
//   reqN_a / reqN_b [WIDTH-1:0]  operands
//   rsp_valid / rsp_ready        response handshake
//   rsp_id                       requester that owns the response
//   rsp_data [WIDTH-1:0]         result word
//   rsp_err                      opcode was illegal
//   busy                         FSM is not idle
// -----------------------------------------------------------------------------

module logic_unit_and #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y_o[gi] = a_i[gi] & b_i[gi];
  end
endmodule

module logic_unit_or #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y_o[gi] = a_i[gi] | b_i[gi];
  end
endmodule

module logic_unit_xor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y_o[gi] = a_i[gi] ^ b_i[gi];
  end
endmodule

module logic_unit_not #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y_o[gi] = ~a_i[gi];
  end
endmodule

module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] NOR2 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;          // 1: requester 1 wins a tie
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;

  logic             idle;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] and_y, or_y, xor_y, not_y, not_a;

  assign idle   = (state_q == IDLE);
  // Requester 1 wins when it is the only one asking, or when both ask and
  // the pointer says it is its turn.
  assign grant1 = req1_valid & (~req0_valid | ptr_q);

  // rst_n gates the readys so nothing is offered while reset is held.
  assign req1_ready = rst_n & idle & grant1;
  assign req0_ready = rst_n & idle & req0_valid & ~grant1;
  assign accept     = req0_ready | req1_ready;

  // The single NOT instance serves both NOT(a) in EXEC and NOT(temp) in NOR2.
  assign not_a = (state_q == NOR2) ? temp_q : a_q;

  logic_unit_and #(.WIDTH(WIDTH)) u_and (.a_i(a_q),   .b_i(b_q), .y_o(and_y));
  logic_unit_or  #(.WIDTH(WIDTH)) u_or  (.a_i(a_q),   .b_i(b_q), .y_o(or_y));
  logic_unit_xor #(.WIDTH(WIDTH)) u_xor (.a_i(a_q),   .b_i(b_q), .y_o(xor_y));
  logic_unit_not #(.WIDTH(WIDTH)) u_not (.a_i(not_a),             .y_o(not_y));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    temp_d      = temp_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = req1_ready;
          op_d    = req1_ready ? req1_op : req0_op;
          a_d     = req1_ready ? req1_a  : req0_a;
          b_d     = req1_ready ? req1_b  : req0_b;
          ptr_d   = ~req1_ready;           // the other requester wins next tie
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        case (op_q)
          OP_AND: rsp_data_d = and_y;
          OP_OR:  rsp_data_d = or_y;
          OP_XOR: rsp_data_d = xor_y;
          OP_NOT: rsp_data_d = not_y;
          OP_NOR: begin
            temp_d      = or_y;
            state_d     = NOR2;
            rsp_valid_d = 1'b0;
          end
          default: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        endcase
      end
      NOR2: begin
        rsp_data_d  = not_y;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      temp_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      temp_q      <= temp_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // id_q only changes on the next accepted request, so it stays stable for
  // the whole response phase.
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = ~idle;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//   Directed vector table, a reset-abort sequence and randomized traffic,
//   all checked against a behavioural model of the arbiter and logic unit.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic        v0;
    logic [2:0]  op0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [2:0]  op1;
    logic [31:0] a1, b1;
    int          hold;      // extra cycles the response is held with rsp_ready=0
    logic        exp_id;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;   // cycles from handshake to rsp_valid
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;
  logic model_fav;          // requester that wins when both are valid

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Result of one operation, straight from the opcode table.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic e, output int lat);
    e   = 1'b0;
    lat = 2;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: d = a ^ b;
      3'd3: d = ~a;
      3'd4: begin d = ~(a | b); lat = 3; end
      default: begin d = 32'h0; e = 1'b1; end
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req0_ready"}, 32'(req0_ready), 0);
    check({tag, "_req1_ready"}, 32'(req1_ready), 0);
    check({tag, "_rsp_valid"},  32'(rsp_valid), 0);
    check({tag, "_rsp_err"},    32'(rsp_err), 0);
    check({tag, "_rsp_id"},     32'(rsp_id), 0);
    check({tag, "_rsp_data"},   rsp_data, 0);
    check({tag, "_busy"},       32'(busy), 0);
  endtask

  // One transaction: present both requesters, check the grant, latency,
  // held response and release. The loser keeps valid high throughout so
  // the readys are checked low while busy, then it is withdrawn in IDLE.
  task automatic run_txn(input vec_t v);
    int   cyc;
    logic loser_valid;
    loser_valid = v.exp_id ? v.v0 : v.v1;
    @(posedge clk); #1;
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    cyc = 0;
    @(negedge clk);
    while (!(req0_ready || req1_ready) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("grant_seen", 32'(req0_ready | req1_ready), 1);
    if (!(req0_ready || req1_ready)) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    check("grant_req0", 32'(req0_ready), 32'(!v.exp_id));
    check("grant_req1", 32'(req1_ready), 32'(v.exp_id));
    model_fav = ~v.exp_id;
    @(posedge clk); #1;
    if (v.exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!rsp_valid) begin
        check("busy_wait", 32'(busy), 1);
        check("readys_wait", 32'({req0_ready, req1_ready}), 0);
      end
    end while (!rsp_valid && cyc < 10);
    check("latency", cyc, v.exp_lat);
    for (int h = 0; h <= v.hold; h++) begin
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_id", 32'(rsp_id), 32'(v.exp_id));
      check("rsp_data", rsp_data, v.exp_data);
      check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      check("readys_resp", 32'({req0_ready, req1_ready}), 0);
      if (h < v.hold) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    // No acceptance in the response-handshake cycle.
    check("readys_rsp_hs", 32'({req0_ready, req1_ready}), 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_clr", 32'(rsp_valid), 0);
    check("rsp_err_clr", 32'(rsp_err), 0);
    check("busy_idle", 32'(busy), 0);
    check("loser_ready", 32'(req0_ready | req1_ready), 32'(loser_valid));
    // Withdraw before the edge: the pending loser must not run.
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("txn %0d id=%0d data=0x%08h err=%0d lat=%0d", txn_no, v.exp_id, v.exp_data, v.exp_err, v.exp_lat);
    txn_no++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t r;
    int   sel;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h0; req0_b = 32'h0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'h0; req1_b = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_fav = 1'b0;

    //          v0  op0     a0            b0            v1  op1     a1            b1            hold id    data          err  lat
    vecs[0] = '{1'b1, 3'd2, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b1, 3'd3, 32'h0000_FFFF, 32'h1234_5678, 1, 1'b0, 32'h5555_5555, 1'b0, 2};
    vecs[1] = '{1'b1, 3'd2, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b1, 3'd3, 32'h0000_FFFF, 32'h1234_5678, 0, 1'b1, 32'hFFFF_0000, 1'b0, 2};
    vecs[2] = '{1'b1, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 3'd0, 32'h0,         32'h0,         0, 1'b0, 32'hF000_F000, 1'b0, 2};
    vecs[3] = '{1'b0, 3'd0, 32'h0,         32'h0,         1'b1, 3'd4, 32'h0000_0001, 32'h8000_0000, 2, 1'b1, 32'h7FFF_FFFE, 1'b0, 3};
    vecs[4] = '{1'b1, 3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 3'd0, 32'h0,         32'h0,         5, 1'b0, 32'h0,         1'b1, 2};
    vecs[5] = '{1'b1, 3'd1, 32'h0,         32'h0,         1'b1, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         1'b1, 2};
    vecs[6] = '{1'b1, 3'd3, 32'h0,         32'h5A5A_5A5A, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 2};
    vecs[7] = '{1'b0, 3'd0, 32'h0,         32'h0,         1'b1, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1, 32'h0,         1'b0, 3};
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset pulse while a NOR issued by requester 0 sits in its second step.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'h0000_0001; req0_b = 32'h8000_0000;
    @(negedge clk);
    check("abort_grant", 32'(req0_ready), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 1);
    check("abort_no_rsp", 32'(rsp_valid), 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    check_reset_outputs("abort_hold");
    req0_valid = 1'b0;
    rst_n = 1'b1;
    model_fav = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_silent", 32'({rsp_valid, busy}), 0);
    end
    // Requester 0 was granted last, yet after reset it must win the tie.
    r = '{1'b1, 3'd4, 32'h0, 32'h0, 1'b1, 3'd1, 32'h1, 32'h2, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3};
    run_txn(r);

    for (int i = 0; i < 40; i++) begin
      sel   = $urandom_range(1, 3);
      r.v0  = sel[0];
      r.v1  = sel[1];
      r.op0 = 3'($urandom_range(0, 7));
      r.op1 = 3'($urandom_range(0, 7));
      r.a0  = $urandom; r.b0 = $urandom;
      r.a1  = $urandom; r.b1 = $urandom;
      r.hold = $urandom_range(0, 3);
      r.exp_id = (r.v0 && r.v1) ? model_fav : r.v1;
      if (r.exp_id) ref_model(r.op1, r.a1, r.b1, r.exp_data, r.exp_err, r.exp_lat);
      else          ref_model(r.op0, r.a0, r.b0, r.exp_data, r.exp_err, r.exp_lat);
      run_txn(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
